// File: rtl/rw_req_scheduler.sv
// rw_req_scheduler
//   Front end for the single read/write transaction FSM. Round-robin picks
//   one of NUM_REQ requesters and drives a level read/write command, holding
//   it stable for the whole transaction. A failed transaction is re-issued
//   after a gap of idle cycles. A hung transaction is abandoned after TIMEOUT
//   cycles. A one-cycle response goes back to the granted requester.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/ready      per-requester handshake (ready: one-hot accept pulse)
//   req_write/page/wdata per-requester command, page and write data
//   rsp_valid            one-hot response pulse
//   rsp_ok/timeout/rdata response status and read data
//   read/write           level command to the transaction FSM
//   FSMmempage           page for the transaction FSM
//   data_from_OS         write data for the transaction FSM
//   read_write_FSM_done  transaction FSM done pulse
//   isValueReadCorrect   transaction FSM success flag, valid with done
//   data_to_OS           transaction FSM read data
module rw_req_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][15:0] req_page,
  input  logic [NUM_REQ-1:0][63:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_ok,
  output logic                     rsp_timeout,
  output logic [63:0]              rsp_rdata,
  output logic                     read,
  output logic                     write,
  output logic [15:0]              FSMmempage,
  output logic [63:0]              data_from_OS,
  input  logic                     read_write_FSM_done,
  input  logic                     isValueReadCorrect,
  input  logic [63:0]              data_to_OS
);

  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  localparam int GAPW = $clog2(RETRY_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [15:0]       page_q, page_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GAPW-1:0]   gap_q, gap_d;
  logic              ok_q, ok_d;
  logic              to_q, to_d;
  logic [63:0]       rdata_q, rdata_d;

  // Round-robin search: first valid requester at or after ptr_q.
  logic              gnt_found;
  logic [GW-1:0]     gnt_idx;
  logic [GW:0]       scan;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (GW+1)'(k);
      if (scan >= (GW+1)'(NUM_REQ)) scan = scan - (GW+1)'(NUM_REQ);
      if (!gnt_found && req_valid[scan[GW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    page_d  = page_q;
    wdata_d = wdata_q;
    retry_d = retry_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    ok_d    = ok_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          gnt_d   = gnt_idx;
          wr_d    = req_write[gnt_idx];
          page_d  = req_page[gnt_idx];
          wdata_d = req_wdata[gnt_idx];
          retry_d = '0;
          ptr_d   = (gnt_idx == GW'(NUM_REQ-1)) ? '0 : gnt_idx + GW'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (read_write_FSM_done) begin
          if (isValueReadCorrect) begin
            ok_d    = 1'b1;
            to_d    = 1'b0;
            rdata_d = wr_q ? 64'd0 : data_to_OS;
            state_d = S_RESP;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            ok_d    = 1'b0;
            to_d    = 1'b0;
            rdata_d = '0;
            state_d = S_RESP;
          end
        // ISSUE is the attempt's first cycle, so the timer reaching
        // TIMEOUT-1 here leaves the command live for exactly TIMEOUT cycles.
        end else if (timer_q == TW'(TIMEOUT-2)) begin
          ok_d    = 1'b0;
          to_d    = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_GAP: begin
        if (gap_q == GAPW'(RETRY_GAP-1)) state_d = S_ISSUE;
        else                             gap_d   = gap_q + GAPW'(1);
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      page_q  <= '0;
      wdata_q <= '0;
      retry_q <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      ok_q    <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      page_q  <= page_d;
      wdata_q <= wdata_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      ok_q    <= ok_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  // Command drops combinationally in the done cycle so the transaction FSM,
  // back in its hold state, never sees a stale level and restarts.
  logic cmd_live;
  logic in_resp;
  assign cmd_live = ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                    !read_write_FSM_done && !rst;
  assign in_resp  = (state_q == S_RESP) && !rst;

  assign read         = cmd_live & ~wr_q;
  assign write        = cmd_live &  wr_q;
  assign FSMmempage   = rst ? 16'd0 : page_q;
  assign data_from_OS = rst ? 64'd0 : wdata_q;

  assign req_ready   = ((state_q == S_IDLE) && gnt_found && !rst) ?
                       (NUM_REQ'(1) << gnt_idx) : '0;
  assign rsp_valid   = in_resp ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_ok      = in_resp & ok_q;
  assign rsp_timeout = in_resp & to_q;
  assign rsp_rdata   = in_resp ? rdata_q : 64'd0;

endmodule

// File: tb/tb_rw_req_scheduler.sv
module tb_rw_req_scheduler;
  localparam int NR = 2, MR = 3, RG = 4, TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
  logic [16*NR-1:0]  req_page;
  logic [64*NR-1:0]  req_wdata;
  logic              rsp_ok, rsp_timeout;
  logic [63:0]       rsp_rdata;
  logic              read, write;
  logic [15:0]       FSMmempage;
  logic [63:0]       data_from_OS;
  logic              done, correct;
  logic [63:0]       data_to_OS;

  always #5 clk = ~clk;

  rw_req_scheduler #(.NUM_REQ(NR), .MAX_RETRY(MR), .RETRY_GAP(RG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_page(req_page), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
    .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata),
    .read(read), .write(write), .FSMmempage(FSMmempage), .data_from_OS(data_from_OS),
    .read_write_FSM_done(done), .isValueReadCorrect(correct), .data_to_OS(data_to_OS)
  );

  int checks = 0, failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model / environment state ----------------
  bit          p_vld[NR];
  bit          p_wr[NR];
  logic [15:0] p_page[NR];
  logic [63:0] p_wdata[NR];
  int          m_ptr, cyc, exp_rise, exp_rsp;
  bit          busy, att_act, att_ok;
  int          cur_g, att_hi, att_k, att_lat;
  bit          cur_wr;
  logic [15:0] cur_page;
  logic [63:0] cur_wdata, att_data;
  bit          done_now, done_next, ok_next, inject_done;
  logic [63:0] data_next;
  bit          e_ok, e_to;
  logic [63:0] e_rdata;
  int          oq_lat[$];
  bit          oq_ok[$];
  bit          rand_out, gen_fixed;
  int          gen_pct;
  int          gnt_log[$];
  int          issues_log[$];
  int          accepts, rsp_count;

  function automatic bit any_pending();
    bit a = 1'b0;
    for (int i = 0; i < NR; i++) a |= p_vld[i];
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) p_vld[i] = 1'b0;
    m_ptr = 0; busy = 0; att_act = 0; exp_rise = -1; exp_rsp = -1;
    done_next = 0; inject_done = 0;
    oq_lat.delete(); oq_ok.delete(); gnt_log.delete();
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = p_vld[i];
      req_write[i]          = p_wr[i];
      req_page[i*16 +: 16]  = p_page[i];
      req_wdata[i*64 +: 64] = p_wdata[i];
    end
  endtask

  // Outcome of a response, by the rules: success, retries exhausted, timeout.
  task automatic set_final(bit ok, bit to, int at);
    e_ok = ok; e_to = to;
    e_rdata = (ok && !cur_wr) ? att_data : 64'd0;
    exp_rsp = at;
    issues_log.push_back(att_k);
  endtask

  // One clock: inputs are already applied; sample at negedge, check, then
  // drive the next cycle's inputs just after the posedge.
  task automatic cycle();
    logic          cmd;
    logic [NR-1:0] exp_rdy, oh;
    int            j, g;
    @(negedge clk);
    cmd = read | write;
    exp_rdy = '0; g = -1;
    if (!busy) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (g < 0 && p_vld[j]) g = j;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      busy = 1; cur_g = g; cur_wr = p_wr[g]; cur_page = p_page[g]; cur_wdata = p_wdata[g];
      p_vld[g] = 1'b0; m_ptr = (g + 1) % NR; exp_rise = cyc + 1; att_k = 0;
      gnt_log.push_back(g); accepts++;
    end
    if (cmd) begin
      if (!att_act) begin
        chk("issue_cycle", cyc, exp_rise);
        att_act = 1; att_hi = 0; att_k++; exp_rise = -1;
        if (oq_lat.size() > 0) begin
          att_lat = oq_lat.pop_front(); att_ok = oq_ok.pop_front();
        end else if (rand_out) begin
          att_lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 8));
          att_ok  = ($urandom_range(0, 2) != 0);
        end else begin
          att_lat = 3; att_ok = 1'b1;
        end
        att_data = {$urandom, $urandom};
      end
      att_hi++;
      chk("cmd_kind", {read, write}, cur_wr ? 2'b01 : 2'b10);
      chk("FSMmempage", FSMmempage, cur_page);
      if (cur_wr) chk("data_from_OS", data_from_OS, cur_wdata);
      if (att_hi == TO) begin
        att_act = 0;
        set_final(1'b0, 1'b1, cyc + 1);
      end else if (att_lat != 0 && att_hi == att_lat) begin
        done_next = 1; ok_next = att_ok; data_next = att_data;
      end
    end else begin
      if (att_act) begin
        if (done_now) begin
          att_act = 0;
          if (att_ok)              set_final(1'b1, 1'b0, cyc + 1);
          else if (att_k - 1 < MR) exp_rise = cyc + RG + 1;
          else                     set_final(1'b0, 1'b0, cyc + 1);
        end else begin
          chk("cmd_held", cmd, 1'b1);
        end
      end
      if (exp_rise == cyc) chk("cmd_reissue", cmd, 1'b1);
    end
    if (exp_rsp == cyc) begin
      oh = '0; oh[cur_g] = 1'b1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_ok", rsp_ok, e_ok);
      chk("rsp_timeout", rsp_timeout, e_to);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      busy = 0; exp_rsp = -1; rsp_count++;
    end else begin
      chk("rsp_idle", rsp_valid, '0);
      chk("rdata_idle", rsp_rdata, 64'd0);
    end
    @(posedge clk); #1;
    cyc++;
    done_now = done_next | inject_done;
    done     = done_now;
    correct  = inject_done ? 1'b1 : ok_next;
    if (done_next) data_to_OS = data_next;
    done_next = 0; inject_done = 0;
    for (int i = 0; i < NR; i++) begin
      if (!p_vld[i] && gen_fixed) begin
        p_vld[i] = 1; p_wr[i] = (i == 1);
        p_page[i] = 16'(16'h0100 * (i + 1)); p_wdata[i] = 64'h55;
      end else if (!p_vld[i] && int'($urandom_range(0, 99)) < gen_pct) begin
        p_vld[i] = 1; p_wr[i] = $urandom_range(0, 1) != 0;
        p_page[i] = 16'($urandom); p_wdata[i] = {$urandom, $urandom};
      end
    end
    apply_reqs();
  endtask

  task automatic drain(string name, int limit);
    int n = 0;
    while ((busy || any_pending()) && n < limit) begin cycle(); n++; end
    checks++;
    if (busy || any_pending()) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic push_out(int lat, bit ok);
    oq_lat.push_back(lat); oq_ok.push_back(ok);
  endtask

  task automatic set_req(int i, bit wr, logic [15:0] page, logic [63:0] wd);
    p_vld[i] = 1; p_wr[i] = wr; p_page[i] = page; p_wdata[i] = wd;
    apply_reqs();
  endtask

  // ---------------- table-driven single read ----------------
  typedef struct {
    logic [1:0]  vld;
    logic        dn, okin;
    logic [1:0]  e_rdy;
    logic        e_rd, e_wr;
    logic [1:0]  e_rsp;
    logic        e_ok;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vt[11];

  initial begin
    int rc;
    int n;
    rst = 1; done = 0; correct = 0; data_to_OS = '0;
    req_valid = '0; req_write = '0; req_page = '0; req_wdata = '0;
    cyc = 0; accepts = 0; rsp_count = 0; rand_out = 0; gen_fixed = 0; gen_pct = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", req_ready, '0);
    chk("rst_cmd", {read, write}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_ok, rsp_timeout}, '0);
    chk("rst_page_data", {FSMmempage, data_from_OS, rsp_rdata}, '0);

    vt[0]  = '{2'b01, 0, 0, 2'b01, 0, 0, 2'b00, 0, 64'd0};
    vt[1]  = '{2'b00, 0, 0, 2'b00, 1, 0, 2'b00, 0, 64'd0};
    vt[2]  = '{2'b00, 0, 0, 2'b00, 1, 0, 2'b00, 0, 64'd0};
    vt[3]  = '{2'b00, 0, 0, 2'b00, 1, 0, 2'b00, 0, 64'd0};
    vt[4]  = '{2'b00, 0, 0, 2'b00, 1, 0, 2'b00, 0, 64'd0};
    vt[5]  = '{2'b00, 0, 0, 2'b00, 1, 0, 2'b00, 0, 64'd0};
    vt[6]  = '{2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 0, 64'd0};
    vt[7]  = '{2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 1, 64'hDEADBEEF_CAFEF00D};
    vt[8]  = '{2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 64'd0};
    vt[9]  = '{2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 0, 64'd0};
    vt[10] = '{2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 64'd0};
    @(posedge clk); #1;
    rst = 0;
    req_page[15:0] = 16'h1234; req_write = '0;
    data_to_OS = 64'hDEADBEEF_CAFEF00D;
    for (int r = 0; r < 11; r++) begin
      req_valid = vt[r].vld; done = vt[r].dn; correct = vt[r].okin;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", r), req_ready, vt[r].e_rdy);
      chk($sformatf("vec%0d_cmd", r), {read, write}, {vt[r].e_rd, vt[r].e_wr});
      if (vt[r].e_rd) chk($sformatf("vec%0d_page", r), FSMmempage, 16'h1234);
      chk($sformatf("vec%0d_rsp", r), {rsp_valid, rsp_ok, rsp_timeout},
          {vt[r].e_rsp, vt[r].e_ok, 1'b0});
      chk($sformatf("vec%0d_rdata", r), rsp_rdata, vt[r].e_rdata);
      @(posedge clk); #1;
    end
    done = 0; correct = 0; req_valid = '0;

    // Clean slate for the model-checked sequences (pointer back to 0).
    rst = 1; @(posedge clk); #1; rst = 0;
    model_clear(); apply_reqs();

    // Contention: both always valid, grants must alternate 0,1,0,1.
    gen_fixed = 1;
    apply_reqs();
    n = 0;
    while (gnt_log.size() < 4 && n < 200) begin cycle(); n++; end
    gen_fixed = 0;
    drain("contention_drain", 200);
    chk("contention_count", gnt_log.size() >= 4, 1'b1);
    if (gnt_log.size() >= 4)
      chk("contention_order", {4'(gnt_log[0]), 4'(gnt_log[1]), 4'(gnt_log[2]), 4'(gnt_log[3])},
          16'h0101);

    // Retry: req 1 write fails twice then succeeds -> 3 issues, one response.
    rc = rsp_count;
    push_out(3, 0); push_out(2, 0); push_out(4, 1);
    set_req(1, 1'b1, 16'hA5A5, 64'h0123_4567_89AB_CDEF);
    drain("retry_drain", 200);
    chk("retry_issues", issues_log[$], 3);
    chk("retry_rsps", rsp_count - rc, 1);

    // Exhaustion: every attempt fails -> 1 + MAX_RETRY issues, ok=0.
    for (int k = 0; k < 4; k++) push_out(2, 0);
    set_req(0, 1'b0, 16'h0F0F, 64'd0);
    drain("exhaust_drain", 200);
    chk("exhaust_issues", issues_log[$], 1 + MR);

    // Timeout: no done at all, then a late done in IDLE must do nothing.
    push_out(0, 0);
    set_req(1, 1'b0, 16'h7777, 64'd0);
    drain("timeout_drain", 200);
    chk("timeout_issues", issues_log[$], 1);
    rc = rsp_count;
    inject_done = 1;
    repeat (4) cycle();
    chk("late_done_rsps", rsp_count - rc, 0);

    // Reset while waiting on the transaction FSM.
    push_out(12, 1);
    set_req(1, 1'b0, 16'h3333, 64'd0);
    n = 0;
    while (!(att_act && att_hi >= 4) && n < 50) begin cycle(); n++; end
    chk("reached_wait", att_act, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_cmd", {read, write}, 2'b00);
    chk("rst_mid_rsp", rsp_valid, '0);
    @(posedge clk); #1;
    rst = 0; done = 0; cyc++;
    model_clear(); done_now = 0;
    @(negedge clk);
    chk("after_rst_cmd", {read, write}, 2'b00);
    chk("after_rst_rsp", rsp_valid, '0);
    @(posedge clk); #1; cyc++;
    set_req(0, 1'b0, 16'h1111, 64'd0);
    set_req(1, 1'b1, 16'h2222, 64'h99);
    drain("post_rst_drain", 200);
    chk("post_rst_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

    // Random traffic and FSM behaviour against the model.
    rand_out = 1; gen_pct = 30;
    rc = rsp_count; accepts = 0;
    repeat (1500) cycle();
    gen_pct = 0;
    drain("random_drain", 400);
    chk("random_rsp_per_accept", rsp_count - rc, accepts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

endmodule
